// File: rtl/present80_encrypt_ctrl_if.sv
// Handshake bundle between the PRESENT-80 controller and its I/O wrapper.
// The master drives plaintext/key and consumes ciphertext; the slave is the controller.
interface present80_encrypt_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] plaintext;
   logic [79:0] key;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] ciphertext;
   logic        busy;
   logic [4:0]  round_idx;

   modport master (
      output in_valid, plaintext, key, out_ready,
      input  in_ready, out_valid, ciphertext, busy, round_idx
   );

   modport slave (
      input  in_valid, plaintext, key, out_ready,
      output in_ready, out_valid, ciphertext, busy, round_idx
   );
endinterface

// File: rtl/present80_encrypt_ctrl.sv
// Iterative PRESENT-80 encryption: one round per clock plus the 80-bit key schedule,
// final K32 whitening folded into the last round edge.
module present80_encrypt_ctrl #(
   parameter int NUM_ROUNDS = 31
) (
   input logic                    clk,
   input logic                    rst,
   present80_encrypt_ctrl_if.slave bus
);

   localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } fsm_e;

   fsm_e        fsm_q, fsm_d;
   logic [63:0] state_q, state_d;
   logic [79:0] key_q, key_d;
   logic [4:0]  round_q, round_d;
   logic [63:0] ct_q, ct_d;

   logic [63:0] rk_add;
   logic [63:0] sb_out;
   logic [63:0] p_out;
   logic [79:0] key_rot;
   logic [79:0] key_next;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;
         4'h1: y = 4'h5;
         4'h2: y = 4'h6;
         4'h3: y = 4'hB;
         4'h4: y = 4'h9;
         4'h5: y = 4'h0;
         4'h6: y = 4'hA;
         4'h7: y = 4'hD;
         4'h8: y = 4'h3;
         4'h9: y = 4'hE;
         4'hA: y = 4'hF;
         4'hB: y = 4'h8;
         4'hC: y = 4'h4;
         4'hD: y = 4'h7;
         4'hE: y = 4'h1;
         default: y = 4'h2;
      endcase
      return y;
   endfunction

   // Round datapath: addRoundKey, 16 parallel S-boxes, bit permutation.
   assign rk_add = state_q ^ key_q[79:16];

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
         assign sb_out[4*gi +: 4] = sbox(rk_add[4*gi +: 4]);
      end
      // pLayer: bit i lands on (16*i) mod 63; bit 63 is a fixed point.
      for (genvar gi = 0; gi < 63; gi++) begin : g_perm
         localparam int DST = (gi * 16) % 63;
         assign p_out[DST] = sb_out[gi];
      end
   endgenerate
   assign p_out[63] = sb_out[63];

   assign key_rot  = {key_q[18:0], key_q[79:19]};
   assign key_next = {sbox(key_rot[79:76]), key_rot[75:20],
                      key_rot[19:15] ^ round_q, key_rot[14:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q   <= S_IDLE;
         state_q <= '0;
         key_q   <= '0;
         round_q <= '0;
         ct_q    <= '0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         key_q   <= key_d;
         round_q <= round_d;
         ct_q    <= ct_d;
      end
   end

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      key_d   = key_q;
      round_d = round_q;
      ct_d    = ct_q;
      unique case (fsm_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               state_d = bus.plaintext;
               key_d   = bus.key;
               round_d = 5'd1;
               fsm_d   = S_RUN;
            end
         end
         S_RUN: begin
            state_d = p_out;
            key_d   = key_next;
            if (round_q == LAST_ROUND) begin
               // Counter parks on the last round index instead of wrapping.
               ct_d  = p_out ^ key_next[79:16];
               fsm_d = S_DONE;
            end else begin
               round_d = round_q + 5'd1;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               round_d = '0;
               fsm_d   = S_IDLE;
            end
         end
         default: fsm_d = S_IDLE;
      endcase
   end

   // All handshake outputs decode registered state only.
   assign bus.in_ready   = (fsm_q == S_IDLE);
   assign bus.out_valid  = (fsm_q == S_DONE);
   assign bus.busy       = (fsm_q != S_IDLE);
   assign bus.ciphertext = ct_q;
   assign bus.round_idx  = round_q;

endmodule

// File: tb/tb_present80_encrypt_ctrl.sv
// Self-checking bench for present80_encrypt_ctrl: known-answer vectors plus random blocks
// compared against a plain algorithmic PRESENT-80 model.
module tb_present80_encrypt_ctrl;
   localparam int NR = 31;

   logic clk = 1'b0;
   logic rst = 1'b1;

   present80_encrypt_ctrl_if bus ();

   present80_encrypt_ctrl #(.NUM_ROUNDS(NR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                             4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [79:0] ref_key_update(input logic [79:0] k, input int r);
      logic [79:0] t;
      t = {k[18:0], k[79:19]};
      t[79:76] = SBOX[t[79:76]];
      t[19:15] = t[19:15] ^ 5'(r);
      return t;
   endfunction

   function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [79:0] k);
      logic [63:0] s;
      logic [63:0] t;
      logic [79:0] kk;
      s  = pt;
      kk = k;
      for (int r = 1; r <= NR; r++) begin
         s = s ^ kk[79:16];
         for (int n = 0; n < 16; n++) s[4*n +: 4] = SBOX[s[4*n +: 4]];
         t = '0;
         for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (i * 16) % 63] = s[i];
         s  = t;
         kk = ref_key_update(kk, r);
      end
      return s ^ kk[79:16];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_block(output logic [63:0] pt, output logic [79:0] k);
      logic [95:0] w;
      pt = {$urandom, $urandom};
      w  = {$urandom, $urandom, $urandom};
      k  = w[79:0];
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      check_val("rst_in_ready", 80'(bus.in_ready), 80'd1);
      check_val("rst_out_valid", 80'(bus.out_valid), 80'd0);
      check_val("rst_busy", 80'(bus.busy), 80'd0);
      check_val("rst_ct", 80'(bus.ciphertext), 80'd0);
      check_val("rst_round", 80'(bus.round_idx), 80'd0);
      rst = 1'b0;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         tick();
         n++;
      end
      check_val("wait_in_ready", 80'(bus.in_ready), 80'd1);
   endtask

   // One full transaction with optional input noise during RUN and a consumer stall.
   task automatic run_block(input logic [63:0] pt, input logic [79:0] k, input int hold,
                            input bit noisy, input bit has_kat, input logic [63:0] kat);
      logic [63:0] exp;
      logic [63:0] npt;
      logic [79:0] nk;
      int cnt;
      exp = ref_encrypt(pt, k);
      wait_ready();
      bus.plaintext = pt;
      bus.key       = k;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      check_val("acc_in_ready", 80'(bus.in_ready), 80'd0);
      check_val("acc_busy", 80'(bus.busy), 80'd1);
      check_val("acc_round", 80'(bus.round_idx), 80'd1);
      cnt = 0;
      while (!bus.out_valid && cnt < 100) begin
         if (noisy) begin
            rand_block(npt, nk);
            bus.plaintext = npt;
            bus.key       = nk;
            bus.in_valid  = 1'($urandom_range(0, 1));
         end
         tick();
         cnt++;
      end
      bus.in_valid = 1'b0;
      check_val("latency", 80'(cnt), 80'(NR));
      check_val("ct_model", 80'(bus.ciphertext), 80'(exp));
      if (has_kat) check_val("ct_kat", 80'(bus.ciphertext), 80'(kat));
      for (int i = 0; i < hold; i++) begin
         tick();
         check_val("hold_valid", 80'(bus.out_valid), 80'd1);
         check_val("hold_ct", 80'(bus.ciphertext), 80'(exp));
         check_val("hold_in_ready", 80'(bus.in_ready), 80'd0);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check_val("post_valid", 80'(bus.out_valid), 80'd0);
      check_val("post_in_ready", 80'(bus.in_ready), 80'd1);
      check_val("post_round", 80'(bus.round_idx), 80'd0);
      $display("block pt=%h key=%h ct=%h exp=%h", pt, k, bus.ciphertext, exp);
   endtask

   initial begin
      logic [63:0] pt;
      logic [79:0] k;
      logic [63:0] expq [$];
      int acc_cyc [$];
      int got;
      int cyc;
      int accepted;
      int n;
      logic r;
      logic v;

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.plaintext = '0;
      bus.key       = '0;
      tick();
      do_reset();

      // Known-answer vectors.
      run_block(64'h0, 80'h0, 0, 1'b0, 1'b1, 64'h5579C1387B228445);
      run_block(64'h0, {80{1'b1}}, 0, 1'b0, 1'b1, 64'hE72C46C0F5945049);
      run_block({64{1'b1}}, 80'h0, 0, 1'b0, 1'b1, 64'hA112FFC72F68417B);
      run_block({64{1'b1}}, {80{1'b1}}, 10, 1'b0, 1'b1, 64'h3333DCD3213210D2);

      // Random blocks with input noise during RUN and random stalls.
      for (int i = 0; i < 4; i++) begin
         rand_block(pt, k);
         run_block(pt, k, $urandom_range(0, 4), 1'b1, 1'b0, 64'h0);
      end

      // Back-to-back with out_ready tied high.
      bus.out_ready = 1'b1;
      got = 0;
      cyc = 0;
      accepted = 0;
      rand_block(pt, k);
      bus.plaintext = pt;
      bus.key       = k;
      bus.in_valid  = 1'b1;
      while (got < 3 && cyc < 300) begin
         r = bus.in_ready;
         v = bus.out_valid;
         if (v) begin
            if (expq.size() > 0) check_val("b2b_ct", 80'(bus.ciphertext), 80'(expq.pop_front()));
            else check_val("b2b_unexpected", 80'(v), 80'd0);
            got++;
         end
         if (r && bus.in_valid) begin
            expq.push_back(ref_encrypt(pt, k));
            acc_cyc.push_back(cyc);
            accepted++;
         end
         tick();
         cyc++;
         if (r) begin
            rand_block(pt, k);
            bus.plaintext = pt;
            bus.key       = k;
            bus.in_valid  = (accepted < 3);
         end
      end
      bus.in_valid  = 1'b0;
      tick();
      bus.out_ready = 1'b0;
      check_val("b2b_count", 80'(got), 80'd3);
      for (int i = 1; i < acc_cyc.size(); i++)
         check_val("b2b_interval", 80'(acc_cyc[i] - acc_cyc[i-1]), 80'(NR + 2));
      $display("back-to-back blocks=%0d accepts=%0d", got, accepted);

      // Abort mid-RUN.
      wait_ready();
      rand_block(pt, k);
      bus.plaintext = pt;
      bus.key       = k;
      bus.in_valid  = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      n = 0;
      while (bus.round_idx != 5'd15 && n < 40) begin
         tick();
         n++;
      end
      check_val("abort_reach15", 80'(bus.round_idx), 80'd15);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("abort_out_valid", 80'(bus.out_valid), 80'd0);
      check_val("abort_in_ready", 80'(bus.in_ready), 80'd1);
      check_val("abort_round", 80'(bus.round_idx), 80'd0);
      check_val("abort_ct", 80'(bus.ciphertext), 80'd0);
      check_val("abort_busy", 80'(bus.busy), 80'd0);
      for (int i = 0; i < 20; i++) begin
         tick();
         check_val("abort_no_pulse", 80'(bus.out_valid), 80'd0);
      end
      $display("abort at round 15 done");
      run_block(64'h0, 80'h0, 0, 1'b0, 1'b1, 64'h5579C1387B228445);

      // Key-schedule single step from key=0.
      bus.plaintext = '0;
      bus.key       = '0;
      bus.in_valid  = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      check_val("key_step_model", dut.key_q, ref_key_update(80'h0, 1));
      check_val("key_step_kat", dut.key_q, 80'hC0000000000000008000);
      $display("key step key_reg=%h", dut.key_q);
      do_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no_finish expected finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/present80_encrypt_ctrl.md
Name: present80_encrypt_ctrl

Overview:
Iterative PRESENT-80 encryption controller. It accepts a 64-bit plaintext and an 80-bit key over a valid/ready handshake. It sequences the existing single-round datapath (doRound: addRoundKey, sBoxLayer x16, pLayer) once per clock and runs the 80-bit key schedule alongside it. It returns the 64-bit ciphertext over a valid/ready handshake and sits between the top-level I/O wrapper and the round datapath.

Parameters:
NUM_ROUNDS, 31, number of doRound iterations before the final key whitening; must be 31 for spec-compliant PRESENT-80, other values for debug only.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  plaintext/key present.
in_ready  output  1  controller can accept a new block.
plaintext  input  64  block to encrypt; sampled on in_valid & in_ready.
key  input  80  cipher key; sampled with plaintext.
out_valid  output  1  ciphertext valid.
out_ready  input  1  consumer accepts ciphertext.
ciphertext  output  64  encryption result; registered.
busy  output  1  high in RUN or DONE.
round_idx  output  5  current round counter, for debug.

Behaviour:
- Only one clock (clk). rst is synchronous and active-high, sampled on the rising edge.
- Reset values: FSM=IDLE, in_ready=1, out_valid=0, busy=0, ciphertext=0, round_idx=0, internal state/key registers=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid=1:
    - state_reg<=plaintext, key_reg<=key, round_idx<=1, go to RUN.
    - in_ready drops in the next cycle.
  - RUN: each cycle:
    - state_reg<=doRound(state_reg, key_reg[79:64-... ]) with round key = key_reg[79:16].
    - key_reg<=key_update(key_reg, round_idx).
    - round_idx<=round_idx+1.
  - Key update, applied in this order:
    1. Rotate left by 61, i.e. k <= {k[18:0], k[79:19]}.
    2. Bits [79:76] <= S(bits[79:76]) using the same 4-bit S-box (sBoxLayer).
    3. Bits [19:15] ^= round_idx[4:0].
  - RUN exit: when round_idx==NUM_ROUNDS, the same edge also loads ciphertext <= doRound_out ^ key_next[79:16] (K32 whitening). It then goes to DONE and sets out_valid=1.
  - DONE: ciphertext and out_valid are held stable until out_ready=1. On out_valid & out_ready, out_valid<=0, round_idx<=0, go to IDLE.
- Latency: the accept edge is edge 0; out_valid rises after edge NUM_ROUNDS (31 cycles). Minimum initiation interval is NUM_ROUNDS+2 cycles with out_ready tied high.
- in_valid in RUN/DONE is ignored. plaintext/key changes after acceptance have no effect.
- There is no combinational path from in_valid to in_ready, or from out_ready to out_valid.
- If out_ready is already high on the cycle DONE is entered, the transfer completes on the next edge.
- rst asserted in any state, including mid-RUN, aborts the operation: all registers return to their reset values on that edge. No partial ciphertext and no out_valid pulse are produced.
- round_idx is 5-bit with no wrap in normal operation, since the maximum used value is 31.

Test Plan:
1. rst, then plaintext=0x0000000000000000, key=0x00000000000000000000 -> out_valid high exactly 31 cycles after accept; ciphertext=0x5579C1387B228445.
2. plaintext=0x0000000000000000, key=0xFFFFFFFFFFFFFFFFFFFF -> ciphertext=0xE72C46C0F5945049. Then plaintext=0xFFFFFFFFFFFFFFFF, key=0 -> 0xA112FFC72F68417B.
3. plaintext=0xFFFFFFFFFFFFFFFF, key=0xFFFFFFFFFFFFFFFFFFFF, out_ready held low 10 cycles -> out_valid and ciphertext=0x3333DCD3213210D2 stable throughout; in_ready stays 0. After out_ready=1 -> IDLE on the next edge.
4. Toggle in_valid and random plaintext/key during RUN -> ignored; result matches the first accepted block. Back-to-back blocks with out_ready=1 -> each accepted 33 cycles apart.
5. Assert rst at round_idx=15 -> next edge: out_valid=0, in_ready=1, round_idx=0, ciphertext=0. A fresh block (case 1) then gives the correct result.
6. Key-schedule check: key=0, one RUN step -> key_reg=0xC0000000000000008000 (S(0)=0xC in bits [79:76], round 1 XOR at bit 15).
